// File: rtl/riscv_str_unleet.sv
// -----------------------------------------------------------------------------
// riscv_str_unleet
//
// Multicycle EX-stage string-op unit that turns leet speak back into plain
// lower-case ASCII. This is the inverse of the STR_OP_LEET encode operation.
// It works on the four bytes of a 32-bit register operand, with byte 0 taken
// from operand_i[7:0]. BYTES_PER_CYCLE bytes are decoded per DECODE cycle.
//
// The unit sits beside riscv_str_ops in EX. It uses the same
// enable/ready/ex_ready handshake as the other multicycle EX units.
//
// Ports
//   clk         in   1             core clock, rising edge
//   rst         in   1             synchronous reset, active-high
//   enable_i    in   1             op request from ID/EX
//   operator_i  in   STR_OP_WIDTH  string-op selector (only STR_OP_UNLEET used)
//   operand_i   in   32            source register value
//   result_o    out  32            decoded word, non-zero only in FINISH
//   ready_o     out  1             1 = can accept / result ready, 0 = stall EX
//   ex_ready_i  in   1             EX stage consumes the result
//
// Byte decode rules ('4'->'a', '3'->'e', '1'->'l', '0'->'o', '5'->'s',
// '7'->'t', 'A'..'Z' -> lower case; everything else unchanged) live in
// unleet_byte().
// -----------------------------------------------------------------------------
module riscv_str_unleet #(
  parameter int unsigned              BYTES_PER_CYCLE = 1,
  parameter int unsigned              STR_OP_WIDTH    = 4,
  parameter logic [STR_OP_WIDTH-1:0]  STR_OP_UNLEET   = STR_OP_WIDTH'(9)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i,
  output logic [31:0]             result_o,
  output logic                    ready_o,
  input  logic                    ex_ready_i
);

  // Chunk size as a 3-bit quantity so that idx + step never overflows (max 3+4=7).
  localparam logic [2:0] STEP3 = 3'(BYTES_PER_CYCLE);
  // Index increment. It truncates to 0 for BYTES_PER_CYCLE=4, but in that case
  // the single chunk is always the last one, so the index is never advanced.
  localparam logic [1:0] STEP2 = 2'(BYTES_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [31:0] work_q;
  logic [31:0] result_q;

  logic [31:0] work_d;
  logic        accept_s;
  logic        last_chunk_s;

  // Decode a single byte. The rules are mutually exclusive, so the first match wins.
  function automatic logic [7:0] unleet_byte(input logic [7:0] b);
    logic [7:0] r;
    case (b)
      8'h34:   r = 8'h61;
      8'h33:   r = 8'h65;
      8'h31:   r = 8'h6C;
      8'h30:   r = 8'h6F;
      8'h35:   r = 8'h73;
      8'h37:   r = 8'h74;
      default: begin
        if ((b >= 8'h41) && (b <= 8'h5A)) begin
          r = b + 8'h20;
        end else begin
          r = b;
        end
      end
    endcase
    return r;
  endfunction

  // A new operation is taken only from IDLE. A request in FINISH is never a back-to-back accept.
  assign accept_s = (state_q == ST_IDLE) && enable_i && (operator_i == STR_OP_UNLEET);

  // The last chunk is reached when it covers byte 3. Using >= keeps idx from ever wrapping.
  assign last_chunk_s = (({1'b0, idx_q} + STEP3) >= 3'd4);

  // Work word with the current chunk (bytes idx .. idx+BYTES_PER_CYCLE-1) decoded.
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) >= {1'b0, idx_q}) && (3'(i) < ({1'b0, idx_q} + STEP3))) begin
        work_d[8*i +: 8] = unleet_byte(work_q[8*i +: 8]);
      end else begin
        work_d[8*i +: 8] = work_q[8*i +: 8];
      end
    end
  end

  // Handshake ready. It drops in the accept cycle itself, so ID/EX stalls immediately.
  always_comb begin
    ready_o = 1'b0;
    case (state_q)
      ST_IDLE:   ready_o = ~accept_s;
      ST_DECODE: ready_o = 1'b0;
      ST_FINISH: ready_o = 1'b1;
      default:   ready_o = 1'b0;
    endcase
  end

  // The controller FSM with its work, index and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      work_q   <= 32'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            work_q  <= operand_i;
            idx_q   <= 2'd0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          work_q <= work_d;
          if (last_chunk_s) begin
            idx_q    <= 2'd0;
            result_q <= work_d;
            state_q  <= ST_FINISH;
          end else begin
            idx_q <= idx_q + STEP2;
          end
        end
        ST_FINISH: begin
          // result_q is cleared on exit, so result_o reads zero outside FINISH.
          if (ex_ready_i) begin
            result_q <= 32'd0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          idx_q    <= 2'd0;
          work_q   <= 32'd0;
          result_q <= 32'd0;
        end
      endcase
    end
  end

  assign result_o = result_q;

endmodule
